fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Single-clock FIFO controller that shares the write port of a `fifo_mem` instance among `NUM_REQ` requesters with round-robin arbitration. It sequences the read port for one consumer. The block owns the write/read pointers, full/empty/count status and the memory address/enable lines. It sits between several producer blocks and one `fifo_mem`, which it drives directly.

## Interface

- `ADDR_SIZE`, 4, memory address width; depth = 2^ADDR_SIZE.
- `DATA_SIZE`, 8, data word width.
- `NUM_REQ`, 4, number of write requesters (2..16).

- `w_clk`  in  1  sole clock; all state updates on rising edge.
- `w_rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*DATA_SIZE  requester i data at bits [i*DATA_SIZE +: DATA_SIZE].
- `req_ready`  out  NUM_REQ  one-hot grant; a push occurs on `req_valid[i] && req_ready[i]`.
- `pop_valid`  out  1  FIFO non-empty; `pop_data` is valid.
- `pop_ready`  in  1  consumer accepts the head word.
- `pop_data`  out  DATA_SIZE  head word (`mem_r_data` passed through).
- `full`  out  1  FIFO holds 2^ADDR_SIZE words.
- `empty`  out  1  FIFO holds 0 words.
- `count`  out  ADDR_SIZE+1  occupancy, 0..2^ADDR_SIZE.
- `mem_w_en`  out  1  memory write enable.
- `mem_w_addr`  out  ADDR_SIZE  memory write address.
- `mem_w_data`  out  DATA_SIZE  memory write data (muxed from the granted requester).
- `mem_w_full`  out  1  equals `full`; drives the memory's write-inhibit input.
- `mem_r_addr`  out  ADDR_SIZE  memory read address.
- `mem_r_data`  in  DATA_SIZE  memory combinational read data.

## Operation

- State:
  - `wr_ptr` and `rd_ptr`, each ADDR_SIZE+1 bits, binary.
  - `last_grant`, an index of $clog2(NUM_REQ) bits.
- `mem_w_addr = wr_ptr[ADDR_SIZE-1:0]` and `mem_r_addr = rd_ptr[ADDR_SIZE-1:0]`.
- `full`: MSBs of `wr_ptr` and `rd_ptr` differ and the low ADDR_SIZE bits are equal.
- `empty`: `wr_ptr == rd_ptr`.
- `count = wr_ptr - rd_ptr`, modulo 2^(ADDR_SIZE+1).
- Arbitration (combinational, round-robin):
  - When `full` is 1, `req_ready` is all zero.
  - Otherwise grant the first i with `req_valid[i]`, scanning `last_grant+1, last_grant+2, …` and wrapping modulo NUM_REQ. `last_grant` itself is scanned last.
  - At most one bit of `req_ready` is high.
  - Valid deasserted means no grant; the arbiter never grants a non-requesting index.
- Push:
  - `mem_w_en = |req_ready`; `mem_w_data = req_data` slice of the granted index.
  - When no grant exists, `mem_w_data` is 0.
  - On the edge: `wr_ptr` increments by 1 and `last_grant` takes the granted index.
  - `last_grant` is unchanged when there is no push.
- Pop:
  - `pop_valid = !empty`; `pop_data = mem_r_data`.
  - On `pop_valid && pop_ready`, `rd_ptr` increments by 1.
  - `pop_ready` while empty is ignored.
- Simultaneous push and pop in one cycle:
  - Both pointers advance and `count` is unchanged.
  - When full, no push is granted, even if a pop occurs in the same cycle; there is no full-bypass.
  - When empty, only the push takes effect; there is no empty-bypass.
- Pointer wrap: pointers wrap naturally at 2^(ADDR_SIZE+1), and addresses wrap at 2^ADDR_SIZE.
- Requester protocol: `req_data[i]` must be stable while `req_valid[i]` is high and not yet accepted. The controller does not store it.

## Timing

- Reset (async assert, synchronous-with-clock deassert by the system):
  - `wr_ptr = 0`, `rd_ptr = 0`, `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - Resulting outputs: `empty = 1`, `full = 0`, `count = 0`, `pop_valid = 0`, `mem_w_en = 0`, `req_ready = 0`.
  - Reset asserted mid-transfer discards all contents immediately; no push or pop completes on that edge.
- All outputs are combinational from registered state plus `req_valid` / `req_data` / `mem_r_data`. There are no registered output stages.
- Push-to-pop latency: a word pushed on edge N is visible on `pop_data` with `pop_valid = 1` after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained.
- `full` / `empty` / `count` reflect all pushes and pops completed up to the last edge.

## Test plan

- **Reset:** assert `w_rst` mid-cycle with 3 words stored.
  - Expect `empty = 1`, `count = 0`, `req_ready = 0` immediately, without a clock edge.
- **Round-robin fairness:** all four `req_valid` held high, pop idle.
  - Expect grants 0,1,2,3,0,1,… on successive cycles.
  - After 16 pushes: `full = 1`, `count = 16`, `req_ready = 0`.
- **Skip idle requesters:** only `req_valid[1]` and `req_valid[3]` high.
  - Expect alternating grants 1,3,1,3; data `0xA1` and `0xA3` pop out in that order.
- **Full with simultaneous pop:** FIFO full, all valid, `pop_ready = 1` for one cycle.
  - That cycle has no grant; next cycle `count = 15` and exactly one grant.
- **Empty with simultaneous push:** FIFO empty, `req_valid[2] = 1`, data `0x5C`, `pop_ready = 1`.
  - That cycle `pop_valid = 0`.
  - Next cycle `pop_valid = 1` and `pop_data = 0x5C`.
- **Wrap-around:** push and pop concurrently for 40 cycles with incrementing data.
  - Popped sequence matches the pushed sequence; `count` stays constant.
  - Pointers pass 31 → 0 without error.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Bundle between fifo_wr_arb, its requesters, its consumer and fifo_mem.
// slave is the controller side; master is the surrounding system.
interface fifo_wr_arb_if #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 8,
   parameter int NUM_REQ   = 4
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_SIZE-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         pop_valid;
   logic                         pop_ready;
   logic [DATA_SIZE-1:0]         pop_data;
   logic                         full;
   logic                         empty;
   logic [ADDR_SIZE:0]           count;
   logic                         mem_w_en;
   logic [ADDR_SIZE-1:0]         mem_w_addr;
   logic [DATA_SIZE-1:0]         mem_w_data;
   logic                         mem_w_full;
   logic [ADDR_SIZE-1:0]         mem_r_addr;
   logic [DATA_SIZE-1:0]         mem_r_data;

   modport slave (
      input  req_valid, req_data, pop_ready, mem_r_data,
      output req_ready, pop_valid, pop_data, full, empty, count,
      output mem_w_en, mem_w_addr, mem_w_data, mem_w_full, mem_r_addr
   );

   modport master (
      output req_valid, req_data, pop_ready, mem_r_data,
      input  req_ready, pop_valid, pop_data, full, empty, count,
      input  mem_w_en, mem_w_addr, mem_w_data, mem_w_full, mem_r_addr
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// FIFO controller: round-robin shared write port, single consumer read
// port, pointer/status ownership for an external fifo_mem.
module fifo_wr_arb #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 8,
   parameter int NUM_REQ   = 4
) (
   input  logic          w_clk,
   input  logic          w_rst,
   fifo_wr_arb_if.slave  bus
);
   localparam int IW = $clog2(NUM_REQ);

   logic [ADDR_SIZE:0]   wr_ptr;
   logic [ADDR_SIZE:0]   rd_ptr;
   logic [IW-1:0]        last_grant;
   logic                 full;
   logic                 empty;
   logic                 grant_vld;
   logic [IW-1:0]        grant_idx;
   logic [NUM_REQ-1:0]   grant_vec;
   logic                 push;
   logic                 pop;

   function automatic logic [IW-1:0] rr_idx(
      input logic [IW-1:0] base,
      input int            k
   );
      return IW'((int'(base) + k) % NUM_REQ);
   endfunction

   assign full  = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                  (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Round-robin scan starting just after the last winner; no grant
   // while full or while reset is held so nothing is accepted then.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      if (!full && !w_rst) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld && bus.req_valid[rr_idx(last_grant, k)]) begin
               grant_vld = 1'b1;
               grant_idx = rr_idx(last_grant, k);
            end
         end
      end
   end

   // One-hot expansion of the winning index.
   always_comb begin
      grant_vec = '0;
      if (grant_vld) begin
         grant_vec[grant_idx] = 1'b1;
      end
   end

   assign push = grant_vld;
   assign pop  = !empty && bus.pop_ready && !w_rst;

   assign bus.req_ready  = grant_vec;
   assign bus.mem_w_en   = grant_vld;
   assign bus.mem_w_data = grant_vld ?
                           bus.req_data[grant_idx*DATA_SIZE +: DATA_SIZE] :
                           '0;
   assign bus.mem_w_addr = wr_ptr[ADDR_SIZE-1:0];
   assign bus.mem_w_full = full;
   assign bus.mem_r_addr = rd_ptr[ADDR_SIZE-1:0];
   assign bus.pop_valid  = !empty;
   assign bus.pop_data   = bus.mem_r_data;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.count      = wr_ptr - rd_ptr;

   // Pointer and arbitration-history update on accepted push/pop.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         last_grant <= IW'(NUM_REQ - 1);
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= grant_idx;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a behavioural fifo_mem and a
// reference model feeding a data scoreboard.
module tb_fifo_wr_arb;
   localparam int AS = 4;
   localparam int DS = 8;
   localparam int NR = 4;
   localparam int DEPTH = 1 << AS;

   logic w_clk = 1'b0;
   logic w_rst = 1'b1;

   fifo_wr_arb_if #(.ADDR_SIZE(AS), .DATA_SIZE(DS), .NUM_REQ(NR)) bus ();

   fifo_wr_arb #(.ADDR_SIZE(AS), .DATA_SIZE(DS), .NUM_REQ(NR)) dut (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .bus   (bus)
   );

   always #5 w_clk = ~w_clk;

   logic [DS-1:0] mem [DEPTH];

   // Behavioural fifo_mem: synchronous write, combinational read.
   always_ff @(posedge w_clk) begin
      if (bus.mem_w_en && !bus.mem_w_full) begin
         mem[bus.mem_w_addr] <= bus.mem_w_data;
      end
   end
   assign bus.mem_r_data = mem[bus.mem_r_addr];

   int total  = 0;
   int passed = 0;
   int m_last;
   int m_cnt;
   int m_wp;
   int m_rp;
   int nxt;
   logic [DS-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DS-1:0] rdat(input int i);
      logic [NR*DS-1:0] v;
      v = bus.req_data;
      return v[i*DS +: DS];
   endfunction

   task automatic set_data(input int i, input logic [DS-1:0] d);
      bus.req_data[i*DS +: DS] = d;
   endtask

   task automatic model_reset();
      m_last = NR - 1;
      m_cnt  = 0;
      m_wp   = 0;
      m_rp   = 0;
      sb.delete();
   endtask

   // One cycle: check outputs against the model at the negedge, then
   // advance the model and the clock. Returns the granted index or -1.
   task automatic step(output int g);
      logic [NR-1:0] exp_rdy;
      logic [DS-1:0] exp_wd;
      bit            pop;
      @(negedge w_clk);
      g = -1;
      if (m_cnt < DEPTH) begin
         for (int k = 1; k <= NR; k++) begin
            if (g < 0 && bus.req_valid[(m_last + k) % NR]) g = (m_last + k) % NR;
         end
      end
      exp_rdy = '0;
      exp_wd  = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         exp_wd     = rdat(g);
      end
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("mem_w_en", 32'(bus.mem_w_en), 32'(g >= 0));
      check("mem_w_data", 32'(bus.mem_w_data), 32'(exp_wd));
      check("mem_w_addr", 32'(bus.mem_w_addr), 32'(m_wp % DEPTH));
      check("mem_r_addr", 32'(bus.mem_r_addr), 32'(m_rp % DEPTH));
      check("count", 32'(bus.count), 32'(m_cnt));
      check("full", 32'(bus.full), 32'(m_cnt == DEPTH));
      check("mem_w_full", 32'(bus.mem_w_full), 32'(m_cnt == DEPTH));
      check("empty", 32'(bus.empty), 32'(m_cnt == 0));
      check("pop_valid", 32'(bus.pop_valid), 32'(m_cnt != 0));
      pop = (m_cnt != 0) && bus.pop_ready;
      if (pop) begin
         check("pop_data", 32'(bus.pop_data), 32'(sb[0]));
         void'(sb.pop_front());
         m_rp = (m_rp + 1) % (2 * DEPTH);
         m_cnt--;
      end
      if (g >= 0) begin
         sb.push_back(exp_wd);
         m_last = g;
         m_wp = (m_wp + 1) % (2 * DEPTH);
         m_cnt++;
      end
      @(posedge w_clk);
      #1;
   endtask

   task automatic drain();
      int g;
      bus.req_valid = '0;
      bus.pop_ready = 1'b1;
      for (int n = 0; n < 2 * DEPTH && m_cnt > 0; n++) step(g);
      check("drained", 32'(m_cnt), 32'd0);
      bus.pop_ready = 1'b0;
   endtask

   initial begin
      int g;
      int seq [$];
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.pop_ready = 1'b0;
      model_reset();
      nxt = 1;

      repeat (2) @(posedge w_clk);
      #1;
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
      check("rst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge w_clk);
      w_rst = 1'b0;
      @(posedge w_clk);
      #1;

      // Store three words, then reset asynchronously mid-cycle.
      bus.req_valid = 4'b0001;
      for (int n = 0; n < 3; n++) begin
         set_data(0, DS'(8'h30 + n));
         step(g);
      end
      check("pre_rst_count", 32'(bus.count), 32'd3);
      bus.req_valid = 4'b1111;
      @(negedge w_clk);
      #2;
      w_rst = 1'b1;
      #1;
      check("async_empty", 32'(bus.empty), 32'd1);
      check("async_count", 32'(bus.count), 32'd0);
      check("async_req_ready", 32'(bus.req_ready), 32'd0);
      check("async_pop_valid", 32'(bus.pop_valid), 32'd0);
      @(posedge w_clk);
      #1;
      check("held_rst_count", 32'(bus.count), 32'd0);
      @(negedge w_clk);
      w_rst = 1'b0;
      model_reset();
      bus.req_valid = '0;
      @(posedge w_clk);
      #1;

      // Round-robin with all requesters active until full.
      for (int i = 0; i < NR; i++) begin
         set_data(i, DS'(nxt));
         nxt++;
      end
      bus.req_valid = 4'b1111;
      for (int n = 0; n < DEPTH + 1; n++) begin
         step(g);
         seq.push_back(g);
         if (g >= 0) begin
            set_data(g, DS'(nxt));
            nxt++;
         end
      end
      for (int n = 0; n < DEPTH; n++) check("rr_order", 32'(seq[n]), 32'(n % NR));
      check("rr_blocked", 32'(seq[DEPTH]), 32'hffff_ffff);
      check("full_after16", 32'(bus.full), 32'd1);
      check("count16", 32'(bus.count), 32'd16);

      // Full with a simultaneous pop: no grant that cycle.
      bus.pop_ready = 1'b1;
      step(g);
      check("full_pop_nogrant", 32'(g), 32'hffff_ffff);
      bus.pop_ready = 1'b0;
      check("count15", 32'(bus.count), 32'd15);
      step(g);
      check("one_grant_after", 32'($countones(seq.size() > 0 ? 4'(1 << g) : 4'd0)), 32'd1);
      drain();

      // Idle requesters are skipped.
      bus.req_valid = 4'b1010;
      set_data(1, 8'hA1);
      set_data(3, 8'hA3);
      seq.delete();
      for (int n = 0; n < 4; n++) begin
         step(g);
         seq.push_back(g);
      end
      for (int n = 0; n < 4; n++) check("skip_idx", 32'(seq[n]), 32'((n % 2) ? 3 : 1));
      check("skip_head", 32'(bus.pop_data), 32'h0A1);
      drain();

      // Empty with simultaneous push: no empty-bypass.
      bus.req_valid = 4'b0100;
      set_data(2, 8'h5C);
      bus.pop_ready = 1'b1;
      check("emp_pop_valid", 32'(bus.pop_valid), 32'd0);
      step(g);
      bus.req_valid = '0;
      check("emp_next_valid", 32'(bus.pop_valid), 32'd1);
      check("emp_next_data", 32'(bus.pop_data), 32'h05C);
      step(g);
      bus.pop_ready = 1'b0;

      // Concurrent push/pop long enough to wrap both pointers.
      bus.req_valid = 4'b0001;
      for (int n = 0; n < 2; n++) begin
         set_data(0, DS'(nxt));
         nxt++;
         step(g);
      end
      bus.pop_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         set_data(0, DS'(nxt));
         nxt++;
         step(g);
         check("wrap_count", 32'(bus.count), 32'd2);
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
